// File: rtl/sc_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin evaluator scheduler.
package sc_rr_scheduler_pkg;

    localparam int SC_N_REQ_DEF = 4;
    localparam int SC_ID_W_DEF  = 2;

    typedef enum logic {
        SC_IDLE = 1'b0,
        SC_EVAL = 1'b1
    } sc_state_e;

endpackage

// File: rtl/Simple_Circuit.sv
// Gate-level evaluator shared by all requesters.
module Simple_Circuit (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic D,
    output logic E
);

    assign D = (A & B) | ~C;
    assign E = ~C;

endmodule

// File: rtl/sc_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr wins.
module sc_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  sel
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    // Descending scan so the smallest rotated offset is the last write.
    always_comb begin
        any   = 1'b0;
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                any   = 1'b1;
                w_off = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (ID_W+1)'(N_REQ))
            w_sum = w_sum - (ID_W+1)'(N_REQ);
        sel = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/sc_rr_scheduler.sv
// Round-robin scheduler sharing one Simple_Circuit among N_REQ requesters.
module sc_rr_scheduler
    import sc_rr_scheduler_pkg::*;
#(
    parameter int N_REQ = SC_N_REQ_DEF,
    parameter int ID_W  = SC_ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    input  logic [N_REQ-1:0] c_in,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             valid,
    output logic             d_out,
    output logic             e_out,
    output logic [ID_W-1:0]  id_out
);

    sc_state_e        r_state;
    sc_state_e        w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_id_out;
    logic [N_REQ-1:0] r_gnt;
    logic             r_a, r_b, r_c;
    logic             r_valid, r_d, r_e;

    logic             w_any;
    logic [ID_W-1:0]  w_sel;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic             w_arb;
    logic             w_d, w_e;

    sc_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .sel (w_sel)
    );

    Simple_Circuit u_eval (
        .A (r_a),
        .B (r_b),
        .C (r_c),
        .D (w_d),
        .E (w_e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= SC_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        unique case (r_state)
            SC_IDLE: begin
                if (en && w_any) begin
                    w_arb       = 1'b1;
                    w_state_nxt = SC_EVAL;
                end
            end
            SC_EVAL: w_state_nxt = SC_IDLE;
        endcase
    end

    assign w_ptr_nxt = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_gnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_c      <= 1'b0;
            r_valid  <= 1'b0;
            r_d      <= 1'b0;
            r_e      <= 1'b0;
            r_id_out <= '0;
        end else begin
            r_valid <= (r_state == SC_EVAL);
            r_gnt   <= w_arb ? (N_REQ'(1) << w_sel) : '0;
            if (w_arb) begin
                r_ptr <= w_ptr_nxt;
                r_id  <= w_sel;
                r_a   <= a_in[w_sel];
                r_b   <= b_in[w_sel];
                r_c   <= c_in[w_sel];
            end
            // Results hold between evaluations.
            if (r_state == SC_EVAL) begin
                r_d      <= w_d;
                r_e      <= w_e;
                r_id_out <= r_id;
            end
        end
    end

    assign gnt    = r_gnt;
    assign busy   = (r_state == SC_EVAL);
    assign valid  = r_valid;
    assign d_out  = r_d;
    assign e_out  = r_e;
    assign id_out = r_id_out;

endmodule

// File: tb/tb_sc_rr_scheduler.sv
// Self-checking bench for sc_rr_scheduler: directed tables plus random vs model.
module tb_sc_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req, a_in, b_in, c_in;
    logic [3:0] gnt;
    logic       busy, valid, d_out, e_out;
    logic [1:0] id_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] abc;
        logic       d;
        logic       e;
    } tt_t;

    tt_t tt[8];

    logic [1:0] m_ptr, m_gid, m_id;
    logic       m_busy, m_valid, m_d, m_e, m_a, m_b, m_c;

    sc_rr_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_in   (c_in),
        .gnt    (gnt),
        .busy   (busy),
        .valid  (valid),
        .d_out  (d_out),
        .e_out  (e_out),
        .id_out (id_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g,
                           input logic b, input logic v, input logic d,
                           input logic e, input logic [1:0] id);
        chk(nm, {6'd0, gnt, busy, valid, d_out, e_out, id_out},
            {6'd0, g, b, v, d, e, id});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic m_reset();
        m_ptr = 0; m_gid = 0; m_id = 0;
        m_busy = 0; m_valid = 0; m_d = 0; m_e = 0;
        m_a = 0; m_b = 0; m_c = 0;
    endtask

    task automatic m_step();
        logic [1:0] k;
        logic       found;
        found = 1'b0;
        if (m_busy) begin
            m_valid = 1'b1;
            m_d     = (m_a & m_b) | ~m_c;
            m_e     = ~m_c;
            m_id    = m_gid;
            m_busy  = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (en && req != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    k = m_ptr + 2'(i);
                    if (!found && req[k]) begin
                        found = 1'b1;
                        m_gid = k;
                    end
                end
                m_a    = a_in[m_gid];
                m_b    = b_in[m_gid];
                m_c    = c_in[m_gid];
                m_ptr  = m_gid + 2'd1;
                m_busy = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] dexp, eexp;
        tt[0] = '{3'b000, 1'b1, 1'b1};
        tt[1] = '{3'b001, 1'b0, 1'b0};
        tt[2] = '{3'b010, 1'b1, 1'b1};
        tt[3] = '{3'b011, 1'b0, 1'b0};
        tt[4] = '{3'b100, 1'b1, 1'b1};
        tt[5] = '{3'b101, 1'b0, 1'b0};
        tt[6] = '{3'b110, 1'b1, 1'b1};
        tt[7] = '{3'b111, 1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b1; req = 0;
        a_in = 0; b_in = 0; c_in = 0;
        repeat (2) @(negedge clk);
        chk_out("reset", 4'b0000, 0, 0, 0, 0, 2'd0);
        rst_n = 1'b1;

        // single request; operands change right after the grant
        req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100; c_in = 4'b0100;
        tick();
        chk_out("single_gnt", 4'b0100, 1, 0, 0, 0, 2'd0);
        req = 0; a_in = 0; b_in = 0; c_in = 0;
        tick();
        chk_out("single_res", 4'b0000, 0, 1, 1, 0, 2'd2);
        tick();
        chk_out("single_hold", 4'b0000, 0, 0, 1, 0, 2'd2);

        for (int i = 0; i < 8; i++) begin
            req  = 4'b0001;
            a_in = {3'b0, tt[i].abc[2]};
            b_in = {3'b0, tt[i].abc[1]};
            c_in = {3'b0, tt[i].abc[0]};
            tick();
            chk("tt_gnt", {12'd0, gnt, busy, valid},
                {12'd0, 4'b0001, 1'b1, 1'b0});
            req = 0;
            tick();
            chk_out("tt_res", 4'b0000, 0, 1, tt[i].d, tt[i].e, 2'd0);
        end

        // fairness with all four requesting continuously
        do_reset();
        req = 4'hF; a_in = 4'b1010; b_in = 4'b1111; c_in = 4'b0011;
        dexp = 4'b1110; eexp = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fair_gnt", {12'd0, gnt, busy, valid},
                {12'd0, 4'b0001 << (i % 4), 1'b1, 1'b0});
            tick();
            chk_out("fair_res", 4'b0000, 0, 1, dexp[i % 4], eexp[i % 4],
                    2'(i % 4));
        end
        req = 0;
        tick();

        // pointer skip and wrap
        do_reset();
        a_in = 0; b_in = 0; c_in = 4'hF;
        req = 4'b1000;
        tick(); chk("wrap_g3", {12'd0, gnt}, 16'b1000);
        req = 0;
        tick(); chk_out("wrap_r3", 4'b0000, 0, 1, 0, 0, 2'd3);
        req = 4'b0110;
        tick(); chk("skip_g1", {12'd0, gnt}, 16'b0010);
        tick(); chk_out("skip_r1", 4'b0000, 0, 1, 0, 0, 2'd1);
        tick(); chk("skip_g2", {12'd0, gnt}, 16'b0100);
        req = 4'b0111;
        tick(); chk_out("skip_r2", 4'b0000, 0, 1, 0, 0, 2'd2);
        tick(); chk("wrap_g0", {12'd0, gnt}, 16'b0001);
        req = 0;
        tick(); chk_out("wrap_r0", 4'b0000, 0, 1, 0, 0, 2'd0);

        // enable gating
        en = 1'b0; req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_off", {12'd0, gnt, busy, valid}, 16'd0);
        end
        en = 1'b1;
        tick(); chk("en_on", {12'd0, gnt}, 16'b0001);
        req = 0;
        tick(); chk("en_res", {15'd0, valid}, 16'd1);

        // asynchronous reset while busy
        req = 4'b0100;
        tick(); chk("pre_rst_busy", {12'd0, gnt, busy}, {12'd0, 4'b0100, 1'b1});
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 0, 0, 0, 0, 2'd0);
        tick();
        rst_n = 1'b1; req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_quiet", {12'd0, gnt, busy, valid}, 16'd0);
        end
        req = 4'b1010;
        tick(); chk("rst_first", {12'd0, gnt}, 16'b0010);
        req = 0;
        tick();

        // random stimulus against the reference model
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 7) != 0);
            req  = 4'($urandom);
            a_in = 4'($urandom);
            b_in = 4'($urandom);
            c_in = 4'($urandom);
            tick();
            m_step();
            chk_out("rand", m_busy ? (4'b0001 << m_gid) : 4'b0000,
                    m_busy, m_valid, m_d, m_e, m_id);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
